apb_arbiter: RTL
================

Name: apb_arbiter

Overview:
- Two-requester APB master that shares the single peripheral APB bus (interrupt controller, timer, etc.) between the CPU data port (m0) and a second master (m1, debug/DMA).
- Sequences the APB setup/access phases, arbitrates round-robin, and returns read data and error status to the granted requester.
- Aborts hung transfers with a bounded timeout. The timeout pulse feeds the interrupt controller's APB error input.

Parameters:
ADDR_WIDTH, 32, width of all address buses
DATA_WIDTH, 32, width of all data buses
TIMEOUT, 255, max ACCESS cycles waiting for pready before abort; counter is $clog2(TIMEOUT+1) bits

Ports:
pclk  input  1  single clock, all logic on rising edge
presetn  input  1  asynchronous, active-low reset
m0_req  input  1  requester 0 transfer request; held with m0_addr/wdata/write/stb until m0_ack
m0_addr  input  ADDR_WIDTH  requester 0 address
m0_wdata  input  DATA_WIDTH  requester 0 write data
m0_write  input  1  1=write, 0=read
m0_stb  input  4  byte strobes
m0_ack  output  1  one-cycle completion pulse
m0_rdata  output  DATA_WIDTH  read data, valid while m0_ack=1
m0_err  output  1  error status, valid while m0_ack=1
m1_req, m1_addr, m1_wdata, m1_write, m1_stb, m1_ack, m1_rdata, m1_err: identical to m0_* for requester 1
paddr  output  ADDR_WIDTH  APB address
pdata  output  DATA_WIDTH  APB write data
pwrite  output  1  APB direction
pstb  output  4  APB strobes
psel  output  1  APB select
penable  output  1  APB enable
prdata  input  DATA_WIDTH  APB read data
pready  input  1  APB ready
perr  input  1  APB slave error
apb_timeout  output  1  one-cycle pulse on timeout abort

Behaviour:
- Reset (async on presetn low, effective immediately, including mid-transfer):
  - State=IDLE; all outputs 0; timeout counter 0; last_grant=1, so m0 wins the first contention.
- FSM states: IDLE, SETUP, ACCESS, RESP. All outputs are registered.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req: grant that requester.
  - Both req: grant the requester that is not last_grant.
  - On grant: latch the granted requester's addr/wdata/write/stb onto paddr/pdata/pwrite/pstb, update last_grant, go to SETUP.
- SETUP: psel=1, penable=0; unconditionally go to ACCESS next cycle.
- ACCESS:
  - psel=1, penable=1; counter increments each cycle.
  - On pready=1: capture prdata (reads only; writes capture 0) and perr, go to RESP.
  - If counter reaches TIMEOUT with pready still 0: capture rdata=0, err=1, pulse apb_timeout, go to RESP.
  - pready takes priority over the timeout in the same cycle.
- RESP:
  - psel=penable=0; counter cleared.
  - Granted requester's ack=1 for exactly one cycle with its rdata/err. The other requester's ack, rdata and err stay 0.
  - Next state IDLE.
- Address/data outputs hold their last values outside transfers; psel and penable are the only qualifiers.
- Latency: req seen in IDLE cycle N gives SETUP N+1 and ACCESS N+2. ack arrives one cycle after the pready cycle (zero-wait slave: ack at N+3).
- Requester rules:
  - The requester drops req, or presents a new transfer, in the cycle after ack.
  - The arbiter returns to IDLE for at least one cycle between transfers, so a deasserted req is never re-granted.
- Request changes while not granted are allowed. The arbiter samples requests only in IDLE.
- No transfer is ever dropped or duplicated. Fairness: with both requests held continuously, grants strictly alternate.

Test Plan:
- Write 0x00000001 to 0x20000004 from m0, slave pready in the 2nd ACCESS cycle -> psel high 3 cycles, penable 2, pdata=0x1, pstb=0xF; m0_ack one pulse with m0_err=0; m1_ack stays 0.
- Read by m1 from 0x20000000 with prdata=0x00000003 -> m1_rdata=0x3 with m1_ack; m0 outputs stay 0.
- m0 and m1 request simultaneously from reset, each holding req for 4 transfers -> grant order m0,m1,m0,m1,m0,m1,m0,m1; one IDLE cycle between transfers.
- Slave never asserts pready, TIMEOUT=255 -> penable high exactly 255 cycles, apb_timeout pulse, m0_err=1, m0_rdata=0; the next transfer completes normally.
- perr=1 with pready -> requester err=1; apb_timeout stays 0.
- presetn low during ACCESS -> psel/penable/ack drop immediately. After release the FSM is IDLE, m0 wins the next contention, and no ack for the aborted transfer ever appears.

Source files
------------

// File: rtl/apb_arbiter.sv
// Two-requester APB master: round-robin arbitration between m0 and m1, APB
// setup/access sequencing, registered responses and a bounded access timeout.
module apb_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  m0_req,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  input  logic                  m0_write,
  input  logic [3:0]            m0_stb,
  output logic                  m0_ack,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic                  m0_err,
  input  logic                  m1_req,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  input  logic                  m1_write,
  input  logic [3:0]            m1_stb,
  output logic                  m1_ack,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  m1_err,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pdata,
  output logic                  pwrite,
  output logic [3:0]            pstb,
  output logic                  psel,
  output logic                  penable,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  perr,
  output logic                  apb_timeout
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    last_grant_q, last_grant_d;
  logic                    grant_q, grant_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0]   pdata_q, pdata_d;
  logic                    pwrite_q, pwrite_d;
  logic [3:0]              pstb_q, pstb_d;
  logic                    psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic                    m0_ack_q, m0_ack_d;
  logic [DATA_WIDTH-1:0]   m0_rdata_q, m0_rdata_d;
  logic                    m0_err_q, m0_err_d;
  logic                    m1_ack_q, m1_ack_d;
  logic [DATA_WIDTH-1:0]   m1_rdata_q, m1_rdata_d;
  logic                    m1_err_q, m1_err_d;
  logic                    apb_timeout_q, apb_timeout_d;

  logic                    pick_m1;
  logic                    done;
  logic [DATA_WIDTH-1:0]   resp_rdata;
  logic                    resp_err;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    last_grant_d  = last_grant_q;
    grant_d       = grant_q;
    paddr_d       = paddr_q;
    pdata_d       = pdata_q;
    pwrite_d      = pwrite_q;
    pstb_d        = pstb_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    m0_ack_d      = 1'b0;
    m0_rdata_d    = '0;
    m0_err_d      = 1'b0;
    m1_ack_d      = 1'b0;
    m1_rdata_d    = '0;
    m1_err_d      = 1'b0;
    apb_timeout_d = 1'b0;
    pick_m1       = 1'b0;
    done          = 1'b0;
    resp_rdata    = '0;
    resp_err      = 1'b0;

    case (state_q)
      IDLE: begin
        // On contention the requester that did not win last time goes next.
        pick_m1 = m1_req && (!m0_req || !last_grant_q);
        if (m0_req || m1_req) begin
          grant_d      = pick_m1;
          last_grant_d = pick_m1;
          paddr_d      = pick_m1 ? m1_addr  : m0_addr;
          pdata_d      = pick_m1 ? m1_wdata : m0_wdata;
          pwrite_d     = pick_m1 ? m1_write : m0_write;
          pstb_d       = pick_m1 ? m1_stb   : m0_stb;
          psel_d       = 1'b1;
          cnt_d        = '0;
          state_d      = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        cnt_d = cnt_q + 1'b1;
        if (pready) begin
          done       = 1'b1;
          resp_rdata = pwrite_q ? '0 : prdata;
          resp_err   = perr;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          done          = 1'b1;
          resp_err      = 1'b1;
          apb_timeout_d = 1'b1;
        end
        if (done) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          state_d   = RESP;
          if (grant_q) begin
            m1_ack_d   = 1'b1;
            m1_rdata_d = resp_rdata;
            m1_err_d   = resp_err;
          end else begin
            m0_ack_d   = 1'b1;
            m0_rdata_d = resp_rdata;
            m0_err_d   = resp_err;
          end
        end
      end
      RESP: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      last_grant_q  <= 1'b1;
      grant_q       <= 1'b0;
      paddr_q       <= '0;
      pdata_q       <= '0;
      pwrite_q      <= 1'b0;
      pstb_q        <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      m0_ack_q      <= 1'b0;
      m0_rdata_q    <= '0;
      m0_err_q      <= 1'b0;
      m1_ack_q      <= 1'b0;
      m1_rdata_q    <= '0;
      m1_err_q      <= 1'b0;
      apb_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      last_grant_q  <= last_grant_d;
      grant_q       <= grant_d;
      paddr_q       <= paddr_d;
      pdata_q       <= pdata_d;
      pwrite_q      <= pwrite_d;
      pstb_q        <= pstb_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      m0_ack_q      <= m0_ack_d;
      m0_rdata_q    <= m0_rdata_d;
      m0_err_q      <= m0_err_d;
      m1_ack_q      <= m1_ack_d;
      m1_rdata_q    <= m1_rdata_d;
      m1_err_q      <= m1_err_d;
      apb_timeout_q <= apb_timeout_d;
    end
  end

  assign paddr       = paddr_q;
  assign pdata       = pdata_q;
  assign pwrite      = pwrite_q;
  assign pstb        = pstb_q;
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign m0_ack      = m0_ack_q;
  assign m0_rdata    = m0_rdata_q;
  assign m0_err      = m0_err_q;
  assign m1_ack      = m1_ack_q;
  assign m1_rdata    = m1_rdata_q;
  assign m1_err      = m1_err_q;
  assign apb_timeout = apb_timeout_q;

endmodule
